// File: rtl/rf_writeback_arbiter.sv
// Shares the register-file write port between ALU, FPU and MUL write-back FIFOs.
// Define WB_RR_EN for round-robin arbitration; otherwise fixed priority ALU > FPU > MUL.

module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                  (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign head  = mem[rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
   end
endmodule

module rf_writeback_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [31:0]       alu_data,
   input  logic              fpu_valid,
   output logic              fpu_ready,
   input  logic [ADDR_W-1:0] fpu_addr,
   input  logic [31:0]       fpu_data,
   input  logic              mul_valid,
   output logic              mul_ready,
   input  logic [1:0]        mul_mode,
   input  logic [31:0]       mul_hi,
   input  logic [31:0]       mul_lo,
   output logic              rf_write_enable,
   output logic [31:0]       rf_write_address,
   output logic [31:0]       rf_write_data_1,
   output logic [31:0]       rf_write_data_2,
   output logic [1:0]        rf_mul,
   output logic              rf_fp_wr,
   output logic              idle
);
   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_FPU = 2'd1,
      SRC_MUL = 2'd2
   } src_e;

   localparam int GW = ADDR_W + 32;
   localparam int MW = 2 + 64;

   logic [GW-1:0] alu_head, fpu_head;
   logic [MW-1:0] mul_head;
   logic          alu_full, fpu_full, mul_full;
   logic          alu_empty, fpu_empty, mul_empty;
   logic          alu_pop, fpu_pop, mul_pop;
   logic [2:0]    req;

   logic          grant_valid;
   src_e          grant_src;
   logic          write;
   logic [31:0]   nxt_addr, nxt_d1, nxt_d2;
   logic [1:0]    nxt_mul;
   logic          nxt_fp;

   assign alu_ready = !alu_full;
   assign fpu_ready = !fpu_full;
   assign mul_ready = !mul_full;

   wb_fifo #(.DEPTH(FIFO_DEPTH), .W(GW)) u_alu_fifo (
      .clk(clk), .rst(rst), .push(alu_valid && alu_ready), .push_data({alu_addr, alu_data}),
      .pop(alu_pop), .head(alu_head), .full(alu_full), .empty(alu_empty));

   wb_fifo #(.DEPTH(FIFO_DEPTH), .W(GW)) u_fpu_fifo (
      .clk(clk), .rst(rst), .push(fpu_valid && fpu_ready), .push_data({fpu_addr, fpu_data}),
      .pop(fpu_pop), .head(fpu_head), .full(fpu_full), .empty(fpu_empty));

   wb_fifo #(.DEPTH(FIFO_DEPTH), .W(MW)) u_mul_fifo (
      .clk(clk), .rst(rst), .push(mul_valid && mul_ready), .push_data({mul_mode, mul_hi, mul_lo}),
      .pop(mul_pop), .head(mul_head), .full(mul_full), .empty(mul_empty));

   assign req = {!mul_empty, !fpu_empty, !alu_empty};

`ifdef WB_RR_EN
   src_e last_grant;
   src_e cand;

   function automatic src_e next_src(input src_e s);
      case (s)
         SRC_ALU: next_src = SRC_FPU;
         SRC_FPU: next_src = SRC_MUL;
         default: next_src = SRC_ALU;
      endcase
   endfunction

   // Search starts just after the previously granted source.
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_ALU;
      cand        = next_src(last_grant);
      for (int k = 0; k < 3; k++) begin
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_src   = cand;
         end
         cand = next_src(cand);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)              last_grant <= SRC_MUL;
      else if (grant_valid) last_grant <= grant_src;
   end
`else
   always_comb begin
      grant_valid = 1'b1;
      grant_src   = SRC_ALU;
      if (req[0])      grant_src = SRC_ALU;
      else if (req[1]) grant_src = SRC_FPU;
      else if (req[2]) grant_src = SRC_MUL;
      else             grant_valid = 1'b0;
   end
`endif

   // Discarded entries still pop and consume the grant.
   assign alu_pop = grant_valid && (grant_src == SRC_ALU);
   assign fpu_pop = grant_valid && (grant_src == SRC_FPU);
   assign mul_pop = grant_valid && (grant_src == SRC_MUL);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      write    = 1'b0;
      nxt_addr = '0;
      nxt_d1   = '0;
      nxt_d2   = '0;
      nxt_mul  = '0;
      nxt_fp   = 1'b0;
      if (grant_valid) begin
         case (grant_src)
            SRC_ALU: begin
               write    = (alu_head[GW-1:32] != '0);
               nxt_addr = 32'(alu_head[GW-1:32]);
               nxt_d1   = alu_head[31:0];
            end
            SRC_FPU: begin
               write    = 1'b1;
               nxt_addr = 32'(fpu_head[GW-1:32]);
               nxt_d1   = fpu_head[31:0];
               nxt_fp   = 1'b1;
            end
            SRC_MUL: begin
               write   = (mul_head[65:64] == 2'd1) || (mul_head[65:64] == 2'd2);
               nxt_mul = mul_head[65:64];
               nxt_d2  = mul_head[63:32];
               nxt_d1  = mul_head[31:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_write_enable  <= 1'b0;
         rf_write_address <= '0;
         rf_write_data_1  <= '0;
         rf_write_data_2  <= '0;
         rf_mul           <= '0;
         rf_fp_wr         <= 1'b0;
      end else begin
         rf_write_enable <= write;
         if (write) begin
            rf_write_address <= nxt_addr;
            rf_write_data_1  <= nxt_d1;
            rf_write_data_2  <= nxt_d2;
            rf_mul           <= nxt_mul;
            rf_fp_wr         <= nxt_fp;
         end
      end
   end

   assign idle = alu_empty && fpu_empty && mul_empty && !rf_write_enable;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: vector table plus contention, fill and reset sequences.
// Expectations adapt to WB_RR_EN where arbitration order differs.

module tb_rf_writeback_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, fpu_valid, mul_valid;
   logic        alu_ready, fpu_ready, mul_ready;
   logic [4:0]  alu_addr, fpu_addr;
   logic [31:0] alu_data, fpu_data, mul_hi, mul_lo;
   logic [1:0]  mul_mode;
   logic        rf_write_enable, rf_fp_wr, idle;
   logic [31:0] rf_write_address, rf_write_data_1, rf_write_data_2;
   logic [1:0]  rf_mul;

   int checks = 0;
   int errors = 0;

   rf_writeback_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_mode(mul_mode), .mul_hi(mul_hi), .mul_lo(mul_lo),
      .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
      .rf_write_data_1(rf_write_data_1), .rf_write_data_2(rf_write_data_2),
      .rf_mul(rf_mul), .rf_fp_wr(rf_fp_wr), .idle(idle));

   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic av; logic [4:0] aa; logic [31:0] ad;
      logic fv; logic [4:0] fa; logic [31:0] fd;
      logic mv; logic [1:0] mm; logic [31:0] mh; logic [31:0] ml;
      logic we; logic [31:0] addr; logic [31:0] d1; logic [31:0] d2;
      logic [1:0] mul; logic fp; logic idle; logic [2:0] rdy;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      fpu_valid = 1'b0; fpu_addr = '0; fpu_data = '0;
      mul_valid = 1'b0; mul_mode = '0; mul_hi = '0; mul_lo = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got[$];
      logic [31:0] exp_seq[10];
      int          a_idx, m_idx;
      logic        hs_a, hs_m;

      //            rst   av  aa     ad              fv  fa      fd              mv  mm    mh       ml        we  addr    d1              d2      mul   fp    idle  rdy
      vecs[0]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h0,         32'h0, 2'd0, 1'b0, 1'b1, 3'b111};
      vecs[1]  = '{1'b0, 1'b1,5'd5, 32'hDEADBEEF,  1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h0,         32'h0, 2'd0, 1'b0, 1'b1, 3'b111};
      vecs[2]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h0,         32'h0, 2'd0, 1'b0, 1'b0, 3'b111};
      vecs[3]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd5, 32'hDEADBEEF,  32'h0, 2'd0, 1'b0, 1'b0, 3'b111};
      vecs[4]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd5, 32'hDEADBEEF,  32'h0, 2'd0, 1'b0, 1'b1, 3'b111};
      vecs[5]  = '{1'b1, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd5, 32'hDEADBEEF,  32'h0, 2'd0, 1'b0, 1'b1, 3'b111};
      vecs[6]  = '{1'b0, 1'b1,5'd3, 32'h11,        1'b1,5'd13,32'hC1D9F1AA,  1'b1,2'd1,32'h1,  32'h2,   1'b0,32'd0, 32'h0,         32'h0, 2'd0, 1'b0, 1'b1, 3'b111};
      vecs[7]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h0,         32'h0, 2'd0, 1'b0, 1'b0, 3'b111};
      vecs[8]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd3, 32'h11,        32'h0, 2'd0, 1'b0, 1'b0, 3'b111};
      vecs[9]  = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd13,32'hC1D9F1AA,  32'h0, 2'd0, 1'b1, 1'b0, 3'b111};
      vecs[10] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b0, 3'b111};
      vecs[11] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b1, 3'b111};
      vecs[12] = '{1'b0, 1'b1,5'd0, 32'h55,        1'b0,5'd0, 32'h0,         1'b1,2'd3,32'h7,  32'h8,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b1, 3'b111};
      vecs[13] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b0, 3'b111};
      vecs[14] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b0, 3'b111};
      vecs[15] = '{1'b0, 1'b1,5'd31,32'hFFFF0000,  1'b0,5'd0, 32'h0,         1'b1,2'd2,32'hA,  32'hB,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b1, 3'b111};
      vecs[16] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'h2,         32'h1, 2'd1, 1'b0, 1'b0, 3'b111};
      vecs[17] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd31,32'hFFFF0000,  32'h0, 2'd0, 1'b0, 1'b0, 3'b111};
      vecs[18] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b1,32'd0, 32'hB,         32'hA, 2'd2, 1'b0, 1'b0, 3'b111};
      vecs[19] = '{1'b0, 1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,         1'b0,2'd0,32'h0,  32'h0,   1'b0,32'd0, 32'hB,         32'hA, 2'd2, 1'b0, 1'b1, 3'b111};

      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         rst = vecs[i].rst;
         alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
         fpu_valid = vecs[i].fv; fpu_addr = vecs[i].fa; fpu_data = vecs[i].fd;
         mul_valid = vecs[i].mv; mul_mode = vecs[i].mm; mul_hi = vecs[i].mh; mul_lo = vecs[i].ml;
         #1;
         check($sformatf("v%0d we", i),    32'(rf_write_enable),  32'(vecs[i].we));
         check($sformatf("v%0d addr", i),  rf_write_address,      vecs[i].addr);
         check($sformatf("v%0d d1", i),    rf_write_data_1,       vecs[i].d1);
         check($sformatf("v%0d d2", i),    rf_write_data_2,       vecs[i].d2);
         check($sformatf("v%0d mul", i),   32'(rf_mul),           32'(vecs[i].mul));
         check($sformatf("v%0d fp", i),    32'(rf_fp_wr),         32'(vecs[i].fp));
         check($sformatf("v%0d idle", i),  32'(idle),             32'(vecs[i].idle));
         check($sformatf("v%0d ready", i), 32'({mul_ready, fpu_ready, alu_ready}), 32'(vecs[i].rdy));
      end

      // ALU and MUL both requesting for 8 cycles; payload held until accepted.
      do_reset();
      a_idx = 0; m_idx = 0;
      got.delete();
      for (int c = 0; c < 30; c++) begin
         alu_valid = (c < 8); alu_addr = 5'(a_idx + 1); alu_data = 32'hA000 + 32'(a_idx);
         mul_valid = (c < 8); mul_mode = 2'd1; mul_hi = 32'(m_idx); mul_lo = 32'hB000 + 32'(m_idx);
         #1;
         if (rf_write_enable) got.push_back(rf_write_data_1);
         hs_a = alu_valid && alu_ready;
         hs_m = mul_valid && mul_ready;
         @(posedge clk); #1;
         if (hs_a) a_idx++;
         if (hs_m) m_idx++;
      end
      clear_inputs();
      for (int k = 0; k < 10; k++) begin
`ifdef WB_RR_EN
         exp_seq[k] = (k % 2 == 0) ? 32'hA000 + 32'(k / 2) : 32'hB000 + 32'(k / 2);
`else
         exp_seq[k] = (k < 8) ? 32'hA000 + 32'(k) : 32'hB000 + 32'(k - 8);
`endif
      end
      check("contend count", 32'(got.size()), 32'd10);
      for (int k = 0; k < 10 && k < got.size(); k++)
         check($sformatf("contend w%0d", k), got[k], exp_seq[k]);

      // FPU FIFO fills while ALU takes the first grant; push while full is refused.
      do_reset();
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1;
      fpu_valid = 1'b1; fpu_addr = 5'd2; fpu_data = 32'hF0;
      #1 check("fill rdy c0", 32'(fpu_ready), 32'd1);
      @(posedge clk); #1;
      alu_data = 32'hA2; fpu_data = 32'hF1;
      #1 check("fill rdy c1", 32'(fpu_ready), 32'd1);
      @(posedge clk); #1;
      alu_valid = 1'b0; fpu_data = 32'hBAD;
      #1 check("fill full", 32'(fpu_ready), 32'd0);
      @(posedge clk); #1;
      fpu_valid = 1'b0;
      got.delete();
      for (int c = 0; c < 12; c++) begin
         #1;
         if (rf_write_enable && rf_fp_wr) got.push_back(rf_write_data_1);
         @(posedge clk); #1;
      end
      check("fill fpu count", 32'(got.size()), 32'd2);
      if (got.size() > 0) check("fill fpu w0", got[0], 32'hF0);
      if (got.size() > 1) check("fill fpu w1", got[1], 32'hF1);
      check("fill rdy end", 32'(fpu_ready), 32'd1);
      check("fill idle end", 32'(idle), 32'd1);

      // Reset with entries queued in every FIFO and one write in flight.
      do_reset();
      for (int c = 0; c < 2; c++) begin
         alu_valid = 1'b1; alu_addr = 5'(7 + c); alu_data = 32'h70 + 32'(c);
         fpu_valid = 1'b1; fpu_addr = 5'(9 + c); fpu_data = 32'h90 + 32'(c);
         mul_valid = 1'b1; mul_mode = 2'd2; mul_hi = 32'h1; mul_lo = 32'h50 + 32'(c);
         @(posedge clk); #1;
      end
      clear_inputs();
      rst = 1'b1;
      #1 check("rst inflight we", 32'(rf_write_enable), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("rst c%0d we", c), 32'(rf_write_enable), 32'd0);
         check($sformatf("rst c%0d idle", c), 32'(idle), 32'd1);
         check($sformatf("rst c%0d ready", c), 32'({mul_ready, fpu_ready, alu_ready}), 32'b111);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
